// File: rtl/y86_pkg.sv
// Shared Y86 writeback definitions: icodes, register IDs, FSM states
// and the icode-to-write-slot decode used by the writeback sequencer.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR1,
    S_WR2
  } state_e;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RA,
    DST_RB,
    DST_RSP
  } dst_e;

  // First write slot of a request; popq adds a second rA <- valM slot.
  typedef struct packed {
    dst_e dst;
    logic use_m;
    logic bad;
  } slot_t;

  function automatic slot_t decode(input logic [3:0] icode);
    slot_t s;
    s = '{dst: DST_NONE, use_m: 1'b0, bad: 1'b0};
    case (icode)
      I_RRMOVQ,
      I_IRMOVQ,
      I_OPQ:    s.dst = DST_RB;
      I_MRMOVQ: begin
        s.dst   = DST_RA;
        s.use_m = 1'b1;
      end
      I_CALL,
      I_RET,
      I_PUSHQ,
      I_POPQ:   s.dst = DST_RSP;
      I_HALT,
      I_NOP,
      I_RMMOVQ,
      I_JXX:    s.dst = DST_NONE;
      default:  s.bad = 1'b1;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dst_addr(
    input dst_e       dst,
    input logic [3:0] ra,
    input logic [3:0] rb
  );
    logic [3:0] a;
    case (dst)
      DST_RA:  a = ra;
      DST_RB:  a = rb;
      DST_RSP: a = RSP;
      default: a = RNONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: turns W-stage requests into 1-2 register writes.
// Ports: clk/rst_n, in_valid/in_ready handshake, icode/rA/rB/valE/valM
// request, wr_en/wr_addr/wr_data write port, busy, err, retire_cnt.
module wb_write_sequencer
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [63:0] wr_data,
  output logic        busy,
  output logic        err,
  output logic [15:0] retire_cnt
);

  state_e      state_q, state_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ra_q, ra_d;
  logic [63:0] valm_q, valm_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        accept;
  slot_t       slot;
  logic [3:0]  a1;

  // Only WR1 of a popq stalls: its second write still has to go out.
  assign in_ready = !(state_q == S_WR1 && icode_q == I_POPQ);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);

  assign slot = decode(icode);
  assign a1   = dst_addr(slot.dst, rA, rB);

  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    ra_d      = ra_q;
    valm_d    = valm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (accept) begin
      state_d = S_WR1;
      icode_d = icode;
      ra_d    = rA;
      valm_d  = valM;
      cnt_d   = cnt_q + 16'd1;
      err_d   = slot.bad;
      if (slot.dst != DST_NONE) begin
        if (a1 == RNONE) begin
          err_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = a1;
          wr_data_d = slot.use_m ? valM : valE;
        end
      end
    end else if (state_q == S_WR1 && icode_q == I_POPQ) begin
      state_d = S_WR2;
      if (ra_q == RNONE) begin
        err_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = ra_q;
        wr_data_d = valm_q;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      icode_q   <= I_NOP;
      ra_q      <= RNONE;
      valm_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      ra_q      <= ra_d;
      valm_q    <= valm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;
  assign retire_cnt = cnt_q;

endmodule

// File: doc/wb_write_sequencer.md
WB_WRITE_SEQUENCER -- requirements
Module: wb_write_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, writeback request from W stage is present.
REQ-004 SHALL have port in_ready, output, 1, the sequencer accepts a request this cycle.
REQ-005 SHALL have ports icode, rA and rB, inputs, 4 bits each, instruction code and register IDs of the request.
REQ-006 SHALL have ports valE and valM, inputs, 64 bits each, ALU result and memory result of the request.
REQ-007 SHALL have ports wr_en (1), wr_addr (4) and wr_data (64), outputs, the single register-file write port.
REQ-008 SHALL have port busy, output, 1, high in any non-IDLE state.
REQ-009 SHALL have port err, output, 1, one-cycle pulse flagging a bad request.
REQ-010 SHALL have port retire_cnt, output, 16 bits, count of accepted requests.

Function
REQ-011 SHALL accept a request on any rising edge where in_valid and in_ready are both high; inputs are captured and ignored at all other times.
REQ-012 SHALL use FSM states IDLE, WR1 and WR2.
- IDLE -> WR1 on accept.
- WR1 -> WR2 when the captured icode is popq (4'hB).
- WR1 -> WR1 on accept of a new request.
- WR1 -> IDLE otherwise.
- WR2 -> WR1 on accept.
- WR2 -> IDLE otherwise.
REQ-013 SHALL drive in_ready high in IDLE, in WR1 when the captured icode is not popq, and in WR2; in_ready SHALL be low in WR1 of a popq.
REQ-014 SHALL register wr_en, wr_addr and wr_data; the first write appears exactly one cycle after acceptance.
REQ-015 SHALL map the WR1 write as follows:
- icode 2, 3, 6: rB <- valE.
- icode 5: rA <- valM.
- icode 8, 9, A: R4 <- valE.
- icode B: R4 <- valE.
REQ-016 SHALL, for popq, perform WR2 as rA <- valM; when rA = 4 the second write lands last, so R4 ends holding valM.
REQ-017 SHALL accept icodes 0, 1, 4 and 7, count them, and hold wr_en low in their WR1 cycle.
REQ-018 SHALL suppress a write whose target is 4'hF and pulse err in that write cycle; other writes of the same request are unaffected.
REQ-019 SHALL treat icode above 4'hB as no-write, pulse err in its WR1 cycle, and still count it.
REQ-020 SHALL hold wr_en low in any cycle with no scheduled write; wr_addr and wr_data SHALL hold their last values.
REQ-021 SHALL sustain one request per cycle for non-popq requests and one per two cycles for popq.
REQ-022 SHALL increment retire_cnt on each accept; it wraps from 16'hFFFF to 0.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE, wr_en 0, wr_addr 0, wr_data 0, err 0, retire_cnt 0; in_ready is 1 and busy is 0.
REQ-024 SHALL, on reset during WR1 or WR2, drop the pending write(s) with no partial write after reset release.

Structure
REQ-025 SHALL take the icode constants, RSP = 4'h4, RNONE = 4'hF and the state enum from shared package y86_pkg.
REQ-026 SHALL implement decode (icode to write slots) as a function in y86_pkg; no sub-module.

Verification
REQ-027 SHALL cover irmovq: icode 3, rB 2, valE 64'h10 accepted at cycle t -> wr_en=1, wr_addr=2, wr_data=64'h10 at t+1, retire_cnt=1.
REQ-028 SHALL cover popq: icode B, rA 3, valE 64'h100, valM 64'hAB.
- t+1: write R4=64'h100, in_ready=0.
- t+2: write R3=64'hAB, in_ready=1.
REQ-029 SHALL cover popq with rA 4: valE 64'h8, valM 64'h55 -> writes R4=8 then R4=55 on consecutive cycles.
REQ-030 SHALL cover back-to-back OPq: rB 1, then rB 6, on consecutive cycles -> writes on consecutive cycles, busy held high, no bubble.
REQ-031 SHALL cover error cases.
- irmovq with rB F -> wr_en=0 and err=1 for one cycle.
- icode C -> err=1 and retire_cnt increments.
REQ-032 SHALL cover reset mid-popq: rst_n low in the WR1 cycle -> no WR2 write, outputs at reset values, retire_cnt=0.
